// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-requester main-memory arbiter.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_IO  = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the arbiter; slave is the arbiter's view.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::MEM_ADDR_W,
    parameter int DATA_W = mem_arb_pkg::MEM_DATA_W
) ();
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_adress;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_indata;
    logic [DATA_W-1:0] mem_outdata;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_outdata,
        output ack0, ack1, rdata, busy, mem_adress, mem_read, mem_write, mem_indata
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_outdata,
        input  ack0, ack1, rdata, busy, mem_adress, mem_read, mem_write, mem_indata
    );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: under contention the requester that did not
// win last time is chosen.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_gnt_i,
    output logic valid_o,
    output logic id_o
);

    // Winner selection
    always_comb begin
        valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            id_o = ~last_gnt_i;
        end else if (req1_i) begin
            id_o = REQ_IO;
        end else begin
            id_o = REQ_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and I/O accesses to main memory: one registered memory strobe
// per transaction, then a one-cycle ack carrying the registered read word.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_adress_q, mem_adress_d;
    logic [DATA_W-1:0] mem_indata_q, mem_indata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;
    logic              pick_valid_s;
    logic              pick_id_s;

    rr_pick2 u_pick (
        .req0_i     (bus.req0),
        .req1_i     (bus.req1),
        .last_gnt_i (last_gnt_q),
        .valid_o    (pick_valid_s),
        .id_o       (pick_id_s)
    );

    // Next-state and next-output logic; strobes and acks default low
    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        id_d         = id_q;
        we_d         = we_q;
        mem_adress_d = mem_adress_q;
        mem_indata_d = mem_indata_q;
        rdata_d      = rdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    state_d = ACCESS;
                    id_d    = pick_id_s;
                    if (pick_id_s == REQ_IO) begin
                        we_d         = bus.we1;
                        mem_adress_d = bus.addr1;
                        mem_indata_d = bus.wdata1;
                    end else begin
                        we_d         = bus.we0;
                        mem_adress_d = bus.addr0;
                        mem_indata_d = bus.wdata0;
                    end
                    mem_read_d  = ~we_d;
                    mem_write_d = we_d;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d    = RESP;
                last_gnt_d = id_q;
                ack0_d     = (id_q == REQ_CPU);
                ack1_d     = (id_q == REQ_IO);
                if (!we_q) begin
                    rdata_d = bus.mem_outdata;
                end else begin
                    rdata_d = rdata_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; last_gnt resets to IO so the CPU wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_q   <= REQ_IO;
            id_q         <= REQ_CPU;
            we_q         <= 1'b0;
            mem_adress_q <= {ADDR_W{1'b0}};
            mem_indata_q <= {DATA_W{1'b0}};
            rdata_q      <= {DATA_W{1'b0}};
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            id_q         <= id_d;
            we_q         <= we_d;
            mem_adress_q <= mem_adress_d;
            mem_indata_q <= mem_indata_d;
            rdata_q      <= rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.rdata      = rdata_q;
    assign bus.busy       = busy_q;
    assign bus.mem_adress = mem_adress_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_indata = mem_indata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4096x16 memory model behind it.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    logic mem_init;
    int   n_cmp;
    int   n_err;

    logic [15:0] mem [0:4095];

    mem_arbiter_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: preload on mem_init, otherwise synchronous write, combinational read
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'(i);
            mem[12'h005] <= 16'hBEEF;
            mem[12'h010] <= 16'hA010;
            mem[12'h020] <= 16'hA020;
        end else if (bus.mem_write) begin
            mem[bus.mem_adress] <= bus.mem_indata;
        end
    end
    assign bus.mem_outdata = mem[bus.mem_adress];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete transaction; called at a negedge with the arbiter idle
    task automatic txn(input logic id, input logic we, input logic [11:0] addr,
                       input logic [15:0] wd, input logic [15:0] exp_rd);
        if (id) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
        end
        step();
        chk("acc_adr",  32'(bus.mem_adress), 32'(addr));
        chk("acc_rw",   32'({bus.mem_read, bus.mem_write}), 32'({~we, we}));
        chk("acc_busy", 32'(bus.busy), 32'd1);
        chk("acc_ack",  32'({bus.ack1, bus.ack0}), 32'd0);
        if (we) chk("acc_ind", 32'(bus.mem_indata), 32'(wd));
        step();
        chk("resp_ack",   32'({bus.ack1, bus.ack0}), id ? 32'd2 : 32'd1);
        chk("resp_rdata", 32'(bus.rdata), 32'(exp_rd));
        chk("resp_rw",    32'({bus.mem_read, bus.mem_write}), 32'd0);
        chk("resp_busy",  32'(bus.busy), 32'd1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        step();
        chk("idle_ack",  32'({bus.ack1, bus.ack0}), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n_ack;
        logic [3:0] ord;
        int ack_at [0:3];

        n_cmp = 0; n_err = 0;
        reset = 1'b1; mem_init = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 12'h000; bus.wdata0 = 16'h0000;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 12'h000; bus.wdata1 = 16'h0000;
        repeat (2) step();
        chk("rst_ack",   32'({bus.ack1, bus.ack0}), 32'd0);
        chk("rst_rw",    32'({bus.mem_read, bus.mem_write}), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_adr",   32'(bus.mem_adress), 32'd0);
        chk("rst_ind",   32'(bus.mem_indata), 32'd0);
        reset = 1'b0; mem_init = 1'b0;
        step();

        // CPU read, I/O write then read back; the write must leave rdata alone
        txn(1'b0, 1'b0, 12'h005, 16'h0000, 16'hBEEF);
        txn(1'b1, 1'b1, 12'h0A0, 16'h1234, 16'hBEEF);
        chk("mem_wr", 32'(mem[12'h0A0]), 32'h1234);
        txn(1'b1, 1'b0, 12'h0A0, 16'h0000, 16'h1234);

        // Contention with both requests held: CPU first, then strict alternation
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h005;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 12'h0A0;
        n_ack = 0; ord = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("ct_overlap", 32'(bus.ack0 & bus.ack1), 32'd0);
            chk("ct_rw",      32'(bus.mem_read & bus.mem_write), 32'd0);
            if (bus.ack0 | bus.ack1) begin
                n_ack++;
                ord = {ord[2:0], bus.ack1};
                chk("ct_rdata", 32'(bus.rdata), bus.ack1 ? 32'h1234 : 32'hBEEF);
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("ct_count", 32'(n_ack), 32'd4);
        chk("ct_order", 32'(ord), 32'h5);
        step();

        // Address change after the request is sampled is ignored
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h010;
        step();
        bus.addr0 = 12'h020;
        chk("hold_adr", 32'(bus.mem_adress), 32'h010);
        step();
        chk("hold_ack",   32'(bus.ack0), 32'd1);
        chk("hold_rdata", 32'(bus.rdata), 32'hA010);
        bus.req0 = 1'b0;
        step();

        // Reset during a write access; afterwards the CPU must win a tie again
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 12'h0B0; bus.wdata1 = 16'h5555;
        step();
        chk("ar_pre_wr", 32'(bus.mem_write), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("ar_wr",    32'(bus.mem_write), 32'd0);
        chk("ar_rd",    32'(bus.mem_read), 32'd0);
        chk("ar_busy",  32'(bus.busy), 32'd0);
        chk("ar_ack",   32'({bus.ack1, bus.ack0}), 32'd0);
        chk("ar_rdata", 32'(bus.rdata), 32'd0);
        bus.req1 = 1'b0; bus.we1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("ar_idle", 32'(bus.busy), 32'd0);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h005;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 12'h0A0;
        step();
        chk("ar_first_adr", 32'(bus.mem_adress), 32'h005);
        step();
        chk("ar_first_ack", 32'({bus.ack1, bus.ack0}), 32'd1);
        chk("ar_first_rd",  32'(bus.rdata), 32'hBEEF);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        step();

        // CPU request held for 9 cycles: three acks, three cycles apart
        bus.req0 = 1'b1; bus.addr0 = 12'h005;
        n_ack = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 8) bus.req0 = 1'b0;
            if (bus.ack0) begin
                if (n_ack < 4) ack_at[n_ack] = i;
                n_ack++;
            end
        end
        chk("hold9_count", 32'(n_ack), 32'd3);
        if (n_ack >= 3) begin
            chk("hold9_gap1", 32'(ack_at[1] - ack_at[0]), 32'd3);
            chk("hold9_gap2", 32'(ack_at[2] - ack_at[1]), 32'd3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the 4096x16 main memory of the basic computer.
- Requester 0: CPU fetch/execute path. Requester 1: I/O/DMA path.
- Grants round-robin. Latches the winner's command and drives the memory's adress/read/write/indata lines for exactly one cycle.
- Registers the returned word and acknowledges the winner with a one-cycle pulse.
- Sits between the control unit / I/O controller and the memory module; the only block allowed to drive memory control lines.

Parameters:
ADDR_W, 12, memory address width (4096 words)
DATA_W, 16, memory word width

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  asynchronous, active-high reset
req0  in  1  requester 0 access request, level, held until ack0
we0  in  1  requester 0: 1=write, 0=read
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
ack0  out  1  requester 0 completion pulse, one cycle
req1  in  1  requester 1 access request, level, held until ack1
we1  in  1  requester 1: 1=write, 0=read
addr1  in  ADDR_W  requester 1 address
wdata1  in  DATA_W  requester 1 write data
ack1  out  1  requester 1 completion pulse, one cycle
rdata  out  DATA_W  read data for the acked requester, valid while ackN=1
busy  out  1  high in ACCESS and RESP
mem_adress  out  ADDR_W  to memory adress
mem_read  out  1  to memory read
mem_write  out  1  to memory write
mem_indata  out  DATA_W  to memory indata
mem_outdata  in  DATA_W  from memory outdata (combinational)

Behaviour:
Reset values:
- State IDLE; ack0, ack1, busy, mem_read, mem_write = 0.
- rdata, mem_adress, mem_indata = 0; last_gnt = 1, so requester 0 wins the first tie.

FSM, state register updated on rising clk:
- IDLE: if req0|req1, select winner, latch addr/we/wdata/id into internal registers, go to ACCESS. Otherwise stay.
- ACCESS: mem_adress=latched addr. mem_read=~we, mem_write=we, high for this cycle only. mem_indata=latched wdata. At the closing edge, capture mem_outdata into rdata (reads only; writes leave rdata unchanged), set last_gnt=id, go to RESP.
- RESP: ack[id]=1 and the other ack=0. Go to IDLE.

Control-line rules:
- mem_read and mem_write are never both 1.
- Both are 0 in IDLE and RESP. mem_adress and mem_indata hold their last latched values outside ACCESS.

Arbitration:
- Only one request: that requester wins.
- Both requesting: the requester != last_gnt wins (strict alternation under contention).

Latency and throughput:
- Request sampled at edge E0; memory access during E0..E1; ack high E1..E2.
- One access per 3 cycles maximum.

Requester handshake:
- Requester drops req after sampling ack=1. IDLE resamples at E3, so a held req starts a new transaction.
- addr/we/wdata changes after E0 are ignored for the current transaction.

ack and rdata:
- ack is a single-cycle pulse, registered, never combinational from req.
- rdata is meaningful only when ackN=1 for a read.

Reset asserted mid-operation:
- Immediately forces IDLE, acks=0, mem_read=mem_write=0.
- A write in ACCESS when reset hits may or may not have updated memory. No ack is issued; the requester re-issues.

Decomposition:
- Package mem_arb_pkg: ADDR_W/DATA_W defaults; state encoding IDLE=2'd0, ACCESS=2'd1, RESP=2'd2; requester IDs REQ_CPU=0, REQ_IO=1.
- One natural sub-module: rr_pick2 (combinational two-way round-robin selector: req0, req1, last_gnt -> valid, id). Everything else lives in mem_arbiter.

Test Plan:
- Reset then req0 read addr 12'h005 (memory preloaded 16'hBEEF): mem_read=1 for exactly one cycle; ack0 pulses 2 edges after request; rdata=16'hBEEF; ack1 stays 0.
- req1 write addr 12'h0A0, wdata 16'h1234, then req1 read 12'h0A0: mem_write pulses once; second transaction returns rdata=16'h1234 with ack1.
- req0 and req1 asserted together, both held, both reads: grant order 0,1,0,1; acks never overlap; mem_read and mem_write never both 1.
- req0 asserted, addr0 changed from 12'h010 to 12'h020 one cycle after E0: access uses 12'h010.
- Async reset asserted during ACCESS of a write: within the same cycle mem_write=0, busy=0, no ack; after release, the next req0 is granted first.
- req0 held high continuously for 9 cycles: exactly 3 ack0 pulses, spaced 3 cycles apart.
